// File: rtl/ppu_oam_dma_sink.sv
// Receiving end of the PPU OAM port: captures $2003/$2004 bus writes (CPU or sprite DMA),
// commits them into a 256-byte OAM on the WR falling edge and tracks OAMADDR / burst progress.
module ppu_oam_dma_sink #(
    parameter logic [15:0] REG_BASE  = 16'h2000,
    parameter logic [15:0] WIN_MASK  = 16'hE000,
    parameter int          BURST_LEN = 256
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        PHI1,
    input  logic [15:0] Addr,
    input  logic        SPR_PPU,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  DB_in,
    output logic [7:0]  DB_out,
    output logic        DB_oe,
    output logic [7:0]  OAMADDR,
    output logic [8:0]  WrCount,
    output logic [7:0]  LastData,
    output logic        BurstDone,
    output logic        WrPulse
);

    localparam logic [2:0] IDX_OAMADDR = 3'd3;
    localparam logic [2:0] IDX_OAMDATA = 3'd4;
    localparam logic [8:0] CNT_MAX     = 9'd511;
    localparam logic [8:0] BURST_CNT   = 9'(BURST_LEN);

    // ---------------- address decode ----------------
    logic       sel;
    logic [2:0] reg_idx;

    assign sel     = SPR_PPU | ((Addr & WIN_MASK) == REG_BASE);
    assign reg_idx = SPR_PPU ? IDX_OAMDATA : Addr[2:0];

    // ---------------- state ----------------
    logic [7:0] mem_q [0:255];

    logic       wr_q;
    logic       block_q;
    logic       hold_valid_q;
    logic [2:0] hold_idx_q;
    logic [7:0] hold_data_q;

    logic [7:0] oamaddr_q,   oamaddr_d;
    logic [8:0] wrcount_q,   wrcount_d;
    logic [7:0] lastdata_q,  lastdata_d;
    logic       wrpulse_q,   wrpulse_d;
    logic       burstdone_q, burstdone_d;

    logic capture_en;
    logic wr_fall;
    logic commit;
    logic commit_addr;
    logic commit_data;
    logic mem_we;

    // block_q keeps a strobe that straddled reset from ever being captured
    assign capture_en  = WR & sel & ~PHI1 & ~block_q;
    assign wr_fall     = wr_q & ~WR;
    assign commit      = wr_fall & hold_valid_q;
    assign commit_addr = commit & (hold_idx_q == IDX_OAMADDR);
    assign commit_data = commit & (hold_idx_q == IDX_OAMDATA);

    // ---------------- capture / edge detect ----------------
    always_ff @(posedge CLK) begin
        if (RES) begin
            wr_q         <= 1'b0;
            block_q      <= 1'b1;
            hold_valid_q <= 1'b0;
            hold_idx_q   <= 3'd0;
            hold_data_q  <= 8'd0;
        end else begin
            wr_q <= WR;
            if (!WR) begin
                block_q <= 1'b0;
            end
            if (capture_en) begin
                hold_valid_q <= 1'b1;
                hold_idx_q   <= reg_idx;
                hold_data_q  <= DB_in;
            end else if (wr_fall) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    // ---------------- commit next-state ----------------
    always_comb begin
        oamaddr_d   = oamaddr_q;
        wrcount_d   = wrcount_q;
        lastdata_d  = lastdata_q;
        wrpulse_d   = 1'b0;
        burstdone_d = 1'b0;
        mem_we      = 1'b0;

        if (commit_addr) begin
            oamaddr_d = hold_data_q;
            wrcount_d = 9'd0;
            wrpulse_d = 1'b1;
        end else if (commit_data) begin
            mem_we     = ~RES;
            lastdata_d = hold_data_q;
            oamaddr_d  = oamaddr_q + 8'd1;
            wrpulse_d  = 1'b1;
            if (wrcount_q != CNT_MAX) begin
                wrcount_d   = wrcount_q + 9'd1;
                // only a real increment can land on the burst length, so saturation never repulses
                burstdone_d = ((wrcount_q + 9'd1) == BURST_CNT);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            oamaddr_q   <= 8'd0;
            wrcount_q   <= 9'd0;
            lastdata_q  <= 8'd0;
            wrpulse_q   <= 1'b0;
            burstdone_q <= 1'b0;
        end else begin
            oamaddr_q   <= oamaddr_d;
            wrcount_q   <= wrcount_d;
            lastdata_q  <= lastdata_d;
            wrpulse_q   <= wrpulse_d;
            burstdone_q <= burstdone_d;
        end
    end

    // OAM contents are deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[oamaddr_q] <= hold_data_q;
        end
    end

    // ---------------- outputs ----------------
    assign DB_out    = mem_q[oamaddr_q];
    assign DB_oe     = RD & sel & ~PHI1 & (reg_idx == IDX_OAMDATA);
    assign OAMADDR   = oamaddr_q;
    assign WrCount   = wrcount_q;
    assign LastData  = lastdata_q;
    assign BurstDone = burstdone_q;
    assign WrPulse   = wrpulse_q;

endmodule

// File: tb/tb_ppu_oam_dma_sink.sv
// Bench for ppu_oam_dma_sink: vector table of bus writes, a commit scoreboard fed by a
// reference model, and hand-written sequences for DMA bursts, reads and reset mid-strobe.
module tb_ppu_oam_dma_sink;

    logic        CLK = 1'b0;
    logic        RES;
    logic        PHI1;
    logic [15:0] Addr;
    logic        SPR_PPU;
    logic        WR;
    logic        RD;
    logic [7:0]  DB_in;
    logic [7:0]  DB_out;
    logic        DB_oe;
    logic [7:0]  OAMADDR;
    logic [8:0]  WrCount;
    logic [7:0]  LastData;
    logic        BurstDone;
    logic        WrPulse;

    ppu_oam_dma_sink dut (
        .CLK(CLK), .RES(RES), .PHI1(PHI1), .Addr(Addr), .SPR_PPU(SPR_PPU),
        .WR(WR), .RD(RD), .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe),
        .OAMADDR(OAMADDR), .WrCount(WrCount), .LastData(LastData),
        .BurstDone(BurstDone), .WrPulse(WrPulse)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_count = 0;
    int burst_count = 0;

    typedef struct {
        logic [7:0] oamaddr;
        logic [8:0] cnt;
        logic [7:0] last;
        logic       burst;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic [7:0] m_addr;
    logic [8:0] m_cnt;
    logic [7:0] m_last;
    logic [7:0] m_mem [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic model_reset();
        m_addr = 8'd0;
        m_cnt  = 9'd0;
        m_last = 8'd0;
    endtask

    task automatic model_commit(input logic [2:0] idx, input logic [7:0] d);
        exp_t e;
        e.burst = 1'b0;
        if (idx == 3'd3) begin
            m_addr = d;
            m_cnt  = 9'd0;
        end else begin
            m_mem[m_addr] = d;
            m_last = d;
            m_addr = m_addr + 8'd1;
            if (m_cnt < 9'd511) begin
                m_cnt = m_cnt + 9'd1;
                e.burst = (m_cnt == 9'd256);
            end
        end
        e.oamaddr = m_addr;
        e.cnt     = m_cnt;
        e.last    = m_last;
        sb_q.push_back(e);
    endtask

    // scoreboard consumer: every WrPulse must match the oldest expected commit
    always @(negedge CLK) begin
        if (BurstDone === 1'b1) burst_count++;
        if (WrPulse === 1'b1) begin
            pulse_count++;
            if (sb_q.size() == 0) begin
                check("unexpected WrPulse", 32'(WrPulse), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb OAMADDR", 32'(OAMADDR), 32'(e.oamaddr));
                check("sb WrCount", 32'(WrCount), 32'(e.cnt));
                check("sb LastData", 32'(LastData), 32'(e.last));
                check("sb BurstDone", 32'(BurstDone), 32'(e.burst));
            end
        end else if (BurstDone === 1'b1) begin
            check("BurstDone without WrPulse", 32'(BurstDone), 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // one bus write: WR held for 'hold' CLKs, then dropped; returns just after the commit edge
    task automatic write_bus(input logic [15:0] a, input logic spr, input logic phi,
                             input logic [7:0] d, input int hold);
        logic       s;
        logic [2:0] idx;
        Addr    = a;
        SPR_PPU = spr;
        PHI1    = phi;
        DB_in   = d;
        WR      = 1'b1;
        repeat (hold) tick();
        WR = 1'b0;
        s   = spr | ((a & 16'hE000) == 16'h2000);
        idx = spr ? 3'd4 : a[2:0];
        if (s && !phi && hold > 0 && (idx == 3'd3 || idx == 3'd4)) model_commit(idx, d);
        tick();
    endtask

    task automatic read_oam(input logic [7:0] where, input logic [7:0] exp, input string name);
        write_bus(16'h2003, 1'b0, 1'b0, where, 1);
        Addr    = 16'h2004;
        SPR_PPU = 1'b0;
        PHI1    = 1'b0;
        RD      = 1'b1;
        #1;
        check(name, 32'(DB_out), 32'(exp));
        RD = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        spr;
        logic        phi1;
        logic [7:0]  data;
        int          hold;
        logic [7:0]  exp_addr;
        logic [8:0]  exp_cnt;
        int          exp_pulse;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int b0;
        logic [7:0] pre;

        vecs[0]  = '{16'h2003, 1'b0, 1'b0, 8'h10, 1,  8'h10, 9'd0, 1};
        vecs[1]  = '{16'h2004, 1'b0, 1'b0, 8'hAA, 12, 8'h11, 9'd1, 1};
        vecs[2]  = '{16'h2003, 1'b0, 1'b0, 8'hFE, 2,  8'hFE, 9'd0, 1};
        vecs[3]  = '{16'h2004, 1'b0, 1'b0, 8'h01, 1,  8'hFF, 9'd1, 1};
        vecs[4]  = '{16'h2004, 1'b0, 1'b0, 8'h02, 3,  8'h00, 9'd2, 1};
        vecs[5]  = '{16'h2004, 1'b0, 1'b0, 8'h03, 1,  8'h01, 9'd3, 1};
        vecs[6]  = '{16'h3FFB, 1'b0, 1'b0, 8'h40, 2,  8'h40, 9'd0, 1};
        vecs[7]  = '{16'h2005, 1'b0, 1'b0, 8'h77, 2,  8'h40, 9'd0, 0};
        vecs[8]  = '{16'h2004, 1'b0, 1'b1, 8'h66, 3,  8'h40, 9'd0, 0};
        vecs[9]  = '{16'h4004, 1'b0, 1'b0, 8'h55, 2,  8'h40, 9'd0, 0};
        vecs[10] = '{16'h2A0C, 1'b0, 1'b0, 8'hB4, 2,  8'h41, 9'd1, 1};
        vecs[11] = '{16'h1234, 1'b1, 1'b0, 8'h9C, 1,  8'h42, 9'd2, 1};

        RES = 1'b1; PHI1 = 1'b1; Addr = 16'h0000; SPR_PPU = 1'b0;
        WR = 1'b0; RD = 1'b0; DB_in = 8'h00;
        model_reset();
        repeat (3) tick();
        RES = 1'b0;
        tick();
        check("reset OAMADDR", 32'(OAMADDR), 32'd0);
        check("reset WrCount", 32'(WrCount), 32'd0);
        check("reset LastData", 32'(LastData), 32'd0);
        check("reset BurstDone", 32'(BurstDone), 32'd0);
        check("reset WrPulse", 32'(WrPulse), 32'd0);
        check("reset DB_oe", 32'(DB_oe), 32'd0);

        for (int k = 0; k < NV; k++) begin
            p0 = pulse_count;
            write_bus(vecs[k].addr, vecs[k].spr, vecs[k].phi1, vecs[k].data, vecs[k].hold);
            tick();
            check($sformatf("vec%0d OAMADDR", k), 32'(OAMADDR), 32'(vecs[k].exp_addr));
            check($sformatf("vec%0d WrCount", k), 32'(WrCount), 32'(vecs[k].exp_cnt));
            check($sformatf("vec%0d pulses", k), 32'(pulse_count - p0), 32'(vecs[k].exp_pulse));
        end

        read_oam(8'h10, 8'hAA, "mem[10]");
        read_oam(8'hFE, 8'h01, "mem[FE]");
        read_oam(8'hFF, 8'h02, "mem[FF]");
        read_oam(8'h00, 8'h03, "mem[00]");
        read_oam(8'h40, 8'hB4, "mem[40]");
        read_oam(8'h41, 8'h9C, "mem[41]");

        // SPR_PPU changing mid-strobe: the last captured sample's index wins
        Addr = 16'h2003; SPR_PPU = 1'b1; PHI1 = 1'b0; DB_in = 8'h99; WR = 1'b1;
        repeat (3) tick();
        SPR_PPU = 1'b0; DB_in = 8'h33;
        tick();
        WR = 1'b0;
        model_commit(3'd3, 8'h33);
        tick(); tick();
        check("spr-drop OAMADDR", 32'(OAMADDR), 32'h33);
        SPR_PPU = 1'b0; DB_in = 8'h11; WR = 1'b1;
        repeat (2) tick();
        SPR_PPU = 1'b1; DB_in = 8'h7E;
        tick();
        WR = 1'b0;
        model_commit(3'd4, 8'h7E);
        tick(); tick();
        check("spr-rise OAMADDR", 32'(OAMADDR), 32'h34);
        check("spr-rise LastData", 32'(LastData), 32'h7E);

        // full sprite DMA burst from $0200-$02FF
        write_bus(16'h2003, 1'b0, 1'b0, 8'h00, 1);
        b0 = burst_count;
        for (int i = 0; i < 256; i++) write_bus(16'h0200 + 16'(i), 1'b1, 1'b0, 8'(i), 1);
        tick();
        check("dma OAMADDR wrap", 32'(OAMADDR), 32'h00);
        check("dma WrCount", 32'(WrCount), 32'd256);
        check("dma BurstDone count", 32'(burst_count - b0), 32'd1);

        // keep writing past the burst until WrCount saturates
        for (int i = 0; i < 260; i++) write_bus(16'h2004, 1'b0, 1'b0, 8'(i) ^ 8'h5A, 1);
        tick();
        check("sat WrCount", 32'(WrCount), 32'd511);
        check("sat BurstDone count", 32'(burst_count - b0), 32'd1);
        check("sat OAMADDR", 32'(OAMADDR), 32'h04);
        for (int i = 0; i < 256; i++) read_oam(8'(i), m_mem[i], $sformatf("dma mem[%0h]", i));

        // WR falling edge with RD high: read shows the pre-commit pointer
        write_bus(16'h2003, 1'b0, 1'b0, 8'h50, 1);
        pre = m_mem[8'h50];
        Addr = 16'h2004; SPR_PPU = 1'b0; PHI1 = 1'b0; DB_in = 8'hE1; WR = 1'b1;
        repeat (2) tick();
        WR = 1'b0; RD = 1'b1;
        model_commit(3'd4, 8'hE1);
        #1;
        check("rd@commit DB_oe", 32'(DB_oe), 32'd1);
        check("rd@commit DB_out pre", 32'(DB_out), 32'(pre));
        tick();
        check("rd@commit OAMADDR", 32'(OAMADDR), 32'h51);
        check("rd@commit DB_out post", 32'(DB_out), 32'(m_mem[8'h51]));
        RD = 1'b0;
        tick();

        // read path: 5C at $20, pointer reset, then $2004 read
        write_bus(16'h2003, 1'b0, 1'b0, 8'h20, 1);
        write_bus(16'h2004, 1'b0, 1'b0, 8'h5C, 1);
        write_bus(16'h2003, 1'b0, 1'b0, 8'h20, 1);
        Addr = 16'h2004; PHI1 = 1'b0; RD = 1'b1;
        #1;
        check("read DB_oe", 32'(DB_oe), 32'd1);
        check("read DB_out", 32'(DB_out), 32'h5C);
        tick(); tick();
        check("read OAMADDR held", 32'(OAMADDR), 32'h20);
        PHI1 = 1'b1;
        #1;
        check("read DB_oe PHI1=1", 32'(DB_oe), 32'd0);
        PHI1 = 1'b0; Addr = 16'h2003;
        #1;
        check("read $2003 DB_oe", 32'(DB_oe), 32'd0);
        RD = 1'b0;
        tick();

        // reset in the middle of a 12-CLK $2004 write
        p0 = pulse_count;
        Addr = 16'h2004; SPR_PPU = 1'b0; PHI1 = 1'b0; DB_in = 8'hC7; WR = 1'b1;
        repeat (5) tick();
        RES = 1'b1;
        tick();
        RES = 1'b0;
        model_reset();
        repeat (6) tick();
        WR = 1'b0;
        repeat (3) tick();
        check("rst-mid OAMADDR", 32'(OAMADDR), 32'd0);
        check("rst-mid WrCount", 32'(WrCount), 32'd0);
        check("rst-mid LastData", 32'(LastData), 32'd0);
        check("rst-mid WrPulse", 32'(WrPulse), 32'd0);
        check("rst-mid pulses", 32'(pulse_count - p0), 32'd0);
        Addr = 16'h2004; RD = 1'b1;
        #1;
        check("rst-mid mem[00] kept", 32'(DB_out), 32'(m_mem[8'h00]));
        RD = 1'b0;
        tick();

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
